// File: rtl/fetch_unit.sv
// fetch_unit: PC and instruction register stage with next-PC selection and halt freeze.
// Optional retired-update counter enabled by FETCH_RETIRE_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        IRWre,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] rs_data,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instruction,
    output logic        halted,
    output logic        pc_misalign,
    output logic [31:0] retired_cnt
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, next_pc;
    logic        mis_q, mis_d, run, accept, halt_op;
    assign run      = state_q == RUN;
    assign accept   = run && PCWre;
    assign halt_op  = ir_q[31:26] == HALT_OP;
    assign pc_plus4 = pc_q + 32'd4;
    always_comb begin
        next_pc = PCSrc == 2'd0 ? pc_plus4 :
                  PCSrc == 2'd1 ? pc_plus4 + {imm_ext[29:0], 2'b00} :
                  PCSrc == 2'd2 ? {rs_data[31:2], 2'b00} :
                                  {pc_plus4[31:28], ir_q[25:0], 2'b00};
        // a halt opcode discards whatever target was selected and freezes the PC
        state_d = (accept && halt_op) ? HALT : state_q;
        pc_d    = (accept && !halt_op) ? next_pc : pc_q;
        ir_d    = (run && IRWre) ? imem_rdata : ir_q;
        mis_d   = mis_q || (accept && PCSrc == 2'd2 && rs_data[1:0] != 2'b00);
    end
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mis_q   <= mis_d;
        end
    end
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign halted      = state_q == HALT;
    assign pc_misalign = mis_q;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    always_comb cnt_d = accept ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge CLK) begin
        if (Rst) cnt_q <= 32'h0;
        else     cnt_q <= cnt_d;
    end
    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan cases plus randomized traffic against a behavioural model.
module tb_fetch_unit;
    logic        CLK = 1'b0, Rst = 1'b1, PCWre = 1'b0, IRWre = 1'b0;
    logic [1:0]  PCSrc = 2'd0;
    logic [31:0] imem_rdata = 32'h0, rs_data = 32'h0, imm_ext = 32'h0;
    logic [31:0] pc, pc_plus4, instruction, retired_cnt;
    logic        halted, pc_misalign;
    int checks = 0, failures = 0;
    logic [31:0] m_pc, m_ir, m_cnt;
    logic        m_halt, m_mis;

    fetch_unit dut (
        .CLK(CLK), .Rst(Rst), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
        .imem_rdata(imem_rdata), .rs_data(rs_data), .imm_ext(imm_ext),
        .pc(pc), .pc_plus4(pc_plus4), .instruction(instruction), .halted(halted),
        .pc_misalign(pc_misalign), .retired_cnt(retired_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("instruction", instruction, m_ir);
        check("halted", {31'b0, halted}, {31'b0, m_halt});
        check("pc_misalign", {31'b0, pc_misalign}, {31'b0, m_mis});
`ifdef FETCH_RETIRE_CNT_EN
        check("retired_cnt", retired_cnt, m_cnt);
`else
        check("retired_cnt", retired_cnt, 32'h0);
`endif
    endtask

    task automatic step(input logic rst, input logic we, input logic [1:0] src, input logic ir_we,
                        input logic [31:0] imem, input logic [31:0] rs, input logic [31:0] imm);
        logic [31:0] tgt, p4;
        Rst = rst; PCWre = we; PCSrc = src; IRWre = ir_we;
        imem_rdata = imem; rs_data = rs; imm_ext = imm;
        p4 = m_pc + 32'd4;
        case (src)
            2'd0: tgt = p4;
            2'd1: tgt = p4 + imm * 32'd4;
            2'd2: tgt = rs & ~32'd3;
            default: tgt = (p4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
        endcase
        @(posedge CLK);
        #1;
        if (rst) begin
            m_pc = 32'h0; m_ir = 32'h0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
        end else if (!m_halt) begin
            if (we) begin
                m_cnt++;
                if (m_ir[31:26] == 6'h3F) m_halt = 1'b1;
                else begin
                    m_pc = tgt;
                    if (src == 2'd2 && rs[1:0] != 2'b00) m_mis = 1'b1;
                end
            end
            if (ir_we) m_ir = imem;
        end
        Rst = 1'b0; PCWre = 1'b0; IRWre = 1'b0;
        check_all();
    endtask

    task automatic jr_to(input logic [31:0] a);
        step(0, 1, 2'd2, 0, 0, a, 0);
    endtask

    task automatic load_ir(input logic [31:0] w);
        step(0, 0, 2'd0, 1, w, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_pc", pc, 32'h0);
        load_ir(32'h2001_0005);
        check("ir_load", instruction, 32'h2001_0005);
        check("ir_load_pc", pc, 32'h0);
        load_ir(32'h0);
        jr_to(32'h40);
        step(0, 1, 2'd1, 0, 0, 0, 32'hFFFF_FFFE);
        check("branch_back", pc, 32'h3C);
        step(0, 1, 2'd0, 0, 0, 0, 0);
        check("seq", pc, 32'h40);
        jr_to(32'h1000_0008);
        load_ir(32'h0C00_0010);
        check("jal_link", pc_plus4, 32'h1000_000C);
        step(0, 1, 2'd3, 0, 0, 0, 0);
        check("jal_target", pc, 32'h1000_0040);
        jr_to(32'h0000_0103);
        check("jr_aligned", pc, 32'h100);
        check("misalign_set", {31'b0, pc_misalign}, 32'h1);
        step(0, 1, 2'd0, 0, 0, 0, 0);
        check("misalign_sticky", {31'b0, pc_misalign}, 32'h1);
        jr_to(32'h20);
        load_ir(32'hFC00_0000);
        step(0, 1, 2'd3, 0, 0, 0, 0);
        check("halt_pc", pc, 32'h20);
        check("halt_flag", {31'b0, halted}, 32'h1);
        step(0, 1, 2'd0, 1, 32'h1234_5678, 0, 0);
        check("halt_frozen_ir", instruction, 32'hFC00_0000);
        check("halt_frozen_pc", pc, 32'h20);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_halt", {31'b0, halted}, 32'h0);
        check("rst_mis", {31'b0, pc_misalign}, 32'h0);
        // counter scenario: 5 accepted updates, halting update, 3 ignored
        for (int i = 0; i < 5; i++) step(0, 1, 2'd0, 0, 0, 0, 0);
        load_ir(32'hFC00_0000);
        step(0, 1, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 0, 0, 0, 0);
`ifdef FETCH_RETIRE_CNT_EN
        check("cnt_six", retired_cnt, 32'd6);
`else
        check("cnt_zero", retired_cnt, 32'd0);
`endif
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[31:26] = 6'h3F;
            step($urandom_range(0, 39) == 0, 1'($urandom), 2'($urandom), 1'($urandom), w,
                 $urandom, $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
